// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and sizing helper for seq_multiplier_param
//
// Purpose : FSM state type and the iteration-counter width function used by
//           both the top-level controller and the datapath.
// Ports   : none (package).

package seq_mult_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_MULT    = 3'd3,
    S_OUT_MSB = 3'd4,
    S_OUT_LSB = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Counter must hold WIDTH itself (one past the last iteration index).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// rtl/seq_mult_dp.sv - shift-add multiplier datapath (operands, accumulator, counter)
//
// Purpose : Holds multiplicand A, multiplier B and the 2*WIDTH accumulator and
//           performs one shift-add (or final shift-subtract in signed mode)
//           iteration per i_step.
// Ports   : clk, rst_n        clock, asynchronous active-low reset
//           i_load_a          capture i_data into A
//           i_load_b          capture i_data into B, clear accumulator and counter
//           i_step            perform one iteration
//           i_signed          two's-complement operands when 1
//           i_data[WIDTH-1:0] operand input
//           o_last            current iteration is the final one
//           o_product         accumulator (final product after WIDTH steps)

module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load_a,
  input  logic               i_load_b,
  input  logic               i_step,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_last;
  logic               w_sub;
  logic [WIDTH:0]     w_upper_ext;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_sum;

  assign w_last = (r_cnt == LAST_CNT);

  // The extra top bit is the carry in unsigned mode and the sign in signed
  // mode; either way it is exactly the bit shifted into the accumulator MSB.
  always_comb begin
    w_upper_ext = {i_signed & r_acc[2*WIDTH-1], r_acc[2*WIDTH-1:WIDTH]};
    w_a_ext     = {i_signed & r_a[WIDTH-1], r_a};
    // B's sign bit carries weight -2^(W-1), so its partial product is subtracted.
    w_sub       = i_signed & w_last;
    w_sum       = w_upper_ext;
    if (r_b[0]) begin
      w_sum = w_sub ? (w_upper_ext - w_a_ext) : (w_upper_ext + w_a_ext);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (i_load_a) begin
        r_a <= i_data;
      end
      if (i_load_b) begin
        r_b   <= i_data;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_step) begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_last    = w_last;
  assign o_product = r_acc;

endmodule

// File: rtl/seq_multiplier_param.sv
// rtl/seq_multiplier_param.sv - bus-loaded sequential shift-add multiplier, sign selectable
//
// Purpose : Loads A then B from a shared bus after a start pulse, multiplies in
//           WIDTH iterations, then drives the product back MSB word first.
// Ports   : clk              rising-edge clock
//           rst_n            asynchronous active-low reset
//           start            request, honoured only in IDLE
//           signed_mode      captured with start; 1 = two's complement
//           databus[W-1:0]   shared bus; driven only while msb_out/lsb_out
//           busy             high whenever not IDLE
//           msb_out          databus carries product[2W-1:W]
//           lsb_out          databus carries product[W-1:0]
//           done             one-cycle completion pulse

module seq_multiplier_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  inout  wire [WIDTH-1:0]  databus,
  output logic             busy,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             done
);

  state_t             r_state;
  state_t             w_next;
  logic               r_signed;
  logic               w_load_a;
  logic               w_load_b;
  logic               w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_bus_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_signed <= signed_mode;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load_a = 1'b0;
    w_load_b = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD_A;
      S_LOAD_A: begin
        w_load_a = 1'b1;
        w_next   = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_load_b = 1'b1;
        w_next   = S_MULT;
      end
      S_MULT: begin
        w_step = 1'b1;
        if (w_last) w_next = S_OUT_MSB;
      end
      S_OUT_MSB: w_next = S_OUT_LSB;
      S_OUT_LSB: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  seq_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load_a  (w_load_a),
    .i_load_b  (w_load_b),
    .i_step    (w_step),
    .i_signed  (r_signed),
    .i_data    (databus),
    .o_last    (w_last),
    .o_product (w_product)
  );

  // Outputs decode the state register only, so reset clears them at once.
  assign busy    = (r_state != S_IDLE);
  assign msb_out = (r_state == S_OUT_MSB);
  assign lsb_out = (r_state == S_OUT_LSB);
  assign done    = (r_state == S_DONE);

  assign w_bus_word = msb_out ? w_product[2*WIDTH-1:WIDTH] : w_product[WIDTH-1:0];
  assign databus    = (msb_out || lsb_out) ? w_bus_word : {WIDTH{1'bz}};

endmodule
